// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: opcodes, FSM encoding, width default.
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // 011 and 111 have no ALU function assigned.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the arbiter.
// rsp_err exists only when ALU_ARB_OPCHECK_EN is defined.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF
);
  // A transfer happens on a rising edge where valid and ready of the same
  // index are both high; valid may not depend on ready.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*3-1:0]      req_op;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
`ifdef ALU_ARB_OPCHECK_EN
  logic                      rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );
`endif

endinterface

// File: rtl/alu_share_arbiter_rr_grant.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
module rr_grant #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic [N-1:0] lo_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick_hi;
  logic [N-1:0] pick_all;

  // Requests at or above the pointer win; otherwise wrap to the lowest one.
  assign lo_mask  = (N'(1) << ptr_i) - N'(1);
  assign req_hi   = req_i & ~lo_mask;
  assign pick_hi  = req_hi & (~req_hi + N'(1));
  assign pick_all = req_i & (~req_i + N'(1));
  assign grant_o  = (|req_hi) ? pick_hi : pick_all;
  assign any_o    = |req_i;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_o[i[PTR_W-1:0]]) idx_o = i[PTR_W-1:0];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: IDLE -> ISSUE -> RESP.
// Optional ALU_ARB_OPCHECK_EN suppresses illegal opcodes and raises rsp_err.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [DATA_W-1:0]   alu_src_a,
  output logic [DATA_W-1:0]   alu_src_b,
  output logic [2:0]          alu_control,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  output state_t              dbg_state_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [2:0]         alu_ctl_q, alu_ctl_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
  logic               illegal_q, illegal_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic [2:0]         op_sel;

  rr_grant #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_grant (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign a_sel  = bus.req_a[grant_idx*DATA_W +: DATA_W];
  assign b_sel  = bus.req_b[grant_idx*DATA_W +: DATA_W];
  assign op_sel = bus.req_op[grant_idx*3 +: 3];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctl_d     = alu_ctl_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    illegal_d     = illegal_q;
    rsp_err_d     = rsp_err_q;
`endif
    bus.req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Ready is the grant itself, so a grant is always a handshake.
        bus.req_ready = grant;
        if (grant_any) begin
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = ST_ISSUE;
`ifdef ALU_ARB_OPCHECK_EN
          illegal_d = op_is_illegal(op_sel);
          if (!op_is_illegal(op_sel)) begin
            alu_a_d   = a_sel;
            alu_b_d   = b_sel;
            alu_ctl_d = op_sel;
          end
`else
          alu_a_d   = a_sel;
          alu_b_d   = b_sel;
          alu_ctl_d = op_sel;
`endif
        end
      end
      ST_ISSUE: begin
        state_d              = ST_RESP;
        rsp_valid_d          = '0;
        rsp_valid_d[owner_q] = 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
        if (illegal_q) begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = 1'b0;
        end
`else
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
`endif
      end
      ST_RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= 3'b000;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      illegal_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctl_q    <= alu_ctl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
      illegal_q    <= illegal_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign alu_src_a      = alu_a_q;
  assign alu_src_b      = alu_b_q;
  assign alu_control    = alu_ctl_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign bus.rsp_err    = rsp_err_q;
`endif
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the ALU ports.
// Honours ALU_ARB_OPCHECK_EN for the illegal-opcode case.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] alu_src_a;
  logic [DATA_W-1:0] alu_src_b;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  state_t            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU
  always_comb begin
    case (alu_control)
      ALU_AND: alu_result = alu_src_a & alu_src_b;
      ALU_OR:  alu_result = alu_src_a | alu_src_b;
      ALU_ADD: alu_result = alu_src_a + alu_src_b;
      ALU_SUB: alu_result = alu_src_a - alu_src_b;
      ALU_MUL: alu_result = alu_src_a * alu_src_b;
      ALU_SLT: alu_result = (alu_src_a < alu_src_b) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready high; starts and ends at #1 after a posedge in IDLE.
  task automatic do_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp_res, input logic exp_zero,
                       input logic [2:0] exp_ctl, input logic exp_err);
    logic [1:0] onehot;
    onehot = 2'(1 << idx);
    bus.req_valid = onehot;
    bus.req_a[idx*32 +: 32] = a;
    bus.req_b[idx*32 +: 32] = b;
    bus.req_op[idx*3 +: 3]  = op;
    #1;
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(onehot));
    step();
    bus.req_valid = '0;
    bus.req_a[idx*32 +: 32] = ~a;
    check({tag, ".issue_state"}, 64'(dbg_state), 64'(ST_ISSUE));
    check({tag, ".alu_control"}, 64'(alu_control), 64'(exp_ctl));
    if (exp_ctl == op) begin
      check({tag, ".alu_src_a"}, 64'(alu_src_a), 64'(a));
      check({tag, ".alu_src_b"}, 64'(alu_src_b), 64'(b));
    end
    check({tag, ".rsp_valid_issue"}, 64'(bus.rsp_valid), 64'(0));
    bus.req_valid = 2'b11;
    #1;
    check({tag, ".req_ready_issue"}, 64'(bus.req_ready), 64'(0));
    bus.req_valid = '0;
    step();
    check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(onehot));
    check({tag, ".rsp_result"}, 64'(bus.rsp_result), 64'(exp_res));
    check({tag, ".rsp_zero"}, 64'(bus.rsp_zero), 64'(exp_zero));
`ifdef ALU_ARB_OPCHECK_EN
    check({tag, ".rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
`else
    if (exp_err) check({tag, ".err_pass_ctl"}, 64'(alu_control), 64'(op));
`endif
    step();
    check({tag, ".rsp_valid_done"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, ".idle"}, 64'(dbg_state), 64'(ST_IDLE));
    check({tag, ".alu_hold"}, 64'(alu_control), 64'(exp_ctl));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 2'b11;
    rst_n         = 1'b0;
    #12;
    check("rst.state",      64'(dbg_state),      64'(ST_IDLE));
    check("rst.req_ready",  64'(bus.req_ready),  64'(0));
    check("rst.rsp_valid",  64'(bus.rsp_valid),  64'(0));
    check("rst.rsp_result", 64'(bus.rsp_result), 64'(0));
    check("rst.rsp_zero",   64'(bus.rsp_zero),   64'(0));
    check("rst.alu_a",      64'(alu_src_a),      64'(0));
    check("rst.alu_b",      64'(alu_src_b),      64'(0));
    check("rst.alu_ctl",    64'(alu_control),    64'(0));
`ifdef ALU_ARB_OPCHECK_EN
    check("rst.rsp_err",    64'(bus.rsp_err),    64'(0));
`endif
    step();
    rst_n = 1'b1;

    do_op("add", 0, 32'd5,      32'd7,          ALU_ADD, 32'd12,       1'b0, ALU_ADD, 1'b0);
    do_op("subz", 1, 32'h1234,  32'h1234,       ALU_SUB, 32'd0,        1'b1, ALU_SUB, 1'b0);
    do_op("and", 0, 32'hF0F0,   32'h0FF0,       ALU_AND, 32'h00F0,     1'b0, ALU_AND, 1'b0);
    do_op("or",  1, 32'hA000_0000, 32'h0000_0005, ALU_OR, 32'hA000_0005, 1'b0, ALU_OR, 1'b0);
    do_op("mul", 0, 32'h0001_0000, 32'h0001_0003, ALU_MUL, 32'h0003_0000, 1'b0, ALU_MUL, 1'b0);
    do_op("sltu", 1, 32'd1,     32'hFFFF_FFFF,  ALU_SLT, 32'd1,        1'b0, ALU_SLT, 1'b0);
`ifdef ALU_ARB_OPCHECK_EN
    do_op("op111", 0, 32'd3, 32'd4, 3'b111, 32'd0, 1'b0, ALU_SLT, 1'b1);
`else
    do_op("op111", 0, 32'd3, 32'd4, 3'b111, 32'd0, 1'b1, 3'b111, 1'b1);
`endif

    // contention from reset
    apply_reset();
    bus.req_a  = {32'd2, 32'd1};
    bus.req_b  = {32'd2, 32'd1};
    bus.req_op = {ALU_ADD, ALU_ADD};
    bus.req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      check($sformatf("rr.grant%0d", g), 64'(bus.req_ready), 64'(exp_g[g]));
      repeat (3) step();
    end
    bus.req_valid = 2'b10;
    #1;
    check("rr.alone1", 64'(bus.req_ready), 64'(2'b10));
    step();
    bus.req_valid = '0;
    repeat (2) step();
    check("rr.alone1_idle", 64'(dbg_state), 64'(ST_IDLE));

    // backpressure on requester 0; rsp_ready[1] high must be ignored
    bus.rsp_ready = 2'b10;
    bus.req_a[31:0] = 32'd9;
    bus.req_b[31:0] = 32'd3;
    bus.req_op[2:0] = ALU_ADD;
    bus.req_valid   = 2'b01;
    step();
    bus.req_valid = 2'b11;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp.rsp_valid%0d", c), 64'(bus.rsp_valid), 64'(2'b01));
      check($sformatf("bp.result%0d", c), 64'(bus.rsp_result), 64'(12));
      check($sformatf("bp.req_ready%0d", c), 64'(bus.req_ready), 64'(0));
      step();
    end
    check("bp.still_resp", 64'(dbg_state), 64'(ST_RESP));
    bus.req_valid = '0;
    bus.rsp_ready = 2'b01;
    step();
    check("bp.idle", 64'(dbg_state), 64'(ST_IDLE));
    check("bp.rsp_valid_done", 64'(bus.rsp_valid), 64'(0));
    bus.rsp_ready = 2'b11;

    // reset during ISSUE
    bus.req_a[63:32] = 32'd1;
    bus.req_b[63:32] = 32'd1;
    bus.req_op[5:3]  = ALU_ADD;
    bus.req_valid    = 2'b10;
    step();
    check("rmid.issue", 64'(dbg_state), 64'(ST_ISSUE));
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rmid.state",     64'(dbg_state),      64'(ST_IDLE));
    check("rmid.alu_a",     64'(alu_src_a),      64'(0));
    check("rmid.alu_ctl",   64'(alu_control),    64'(0));
    check("rmid.rsp_valid", 64'(bus.rsp_valid),  64'(0));
    check("rmid.result",    64'(bus.rsp_result), 64'(0));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rmid.no_rsp%0d", c), 64'(bus.rsp_valid), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU among `NUM_REQ` requesters, for example a pipeline EX stage and a multi-cycle address/branch unit. It accepts one operation at a time over a valid/ready handshake, drives the ALU operand and control inputs from registered values, and captures the ALU result and zero flag. It returns the result to the granted requester over a valid/ready response channel. It sits between the requesters and the ALU, and is the only driver of the ALU inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_W`, 32: operand and result width.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req_valid  in  NUM_REQ`: per-requester request valid.
- `req_ready  out  NUM_REQ`: per-requester accept; at most one bit high.
- `req_a  in  NUM_REQ*DATA_W`: flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_b  in  NUM_REQ*DATA_W`: flattened operand B, same packing.
- `req_op  in  NUM_REQ*3`: flattened ALU control code per requester.
- `rsp_valid  out  NUM_REQ`: response valid; one-hot, to the owning requester only.
- `rsp_ready  in  NUM_REQ`: per-requester response accept.
- `rsp_result  out  DATA_W`: shared result bus, meaningful only where `rsp_valid` is set.
- `rsp_zero  out  1`: captured zero flag.
- `rsp_err  out  1`: illegal-opcode flag; present only when the macro below is defined.
- `alu_src_a  out  DATA_W`: drives the ALU A operand.
- `alu_src_b  out  DATA_W`: drives the ALU B operand.
- `alu_control  out  3`: drives the ALU control input.
- `alu_result  in  DATA_W`: ALU result.
- `alu_zero  in  1`: ALU zero flag.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - Grant goes to the first requester with `req_valid` high, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready` is combinational: it is high for the granted index only.
  - On the handshake, latch a, b, op and the owner index, and set `rr_ptr` to owner+1 mod `NUM_REQ`.
  - Next state is ISSUE.
  - With no valid request, stay in IDLE and leave `rr_ptr` unchanged.
- **ISSUE**
  - `alu_src_a`, `alu_src_b` and `alu_control` carry the latched values.
  - At the end of the cycle, capture `alu_result` and `alu_zero` into the response registers.
  - Next state is RESP.
- **RESP**
  - `rsp_valid[owner]` is high.
  - Stay in RESP until `rsp_ready[owner]` is high, then go to IDLE.
  - `rsp_ready` on other indices is ignored.
- `req_ready` is 0 in ISSUE and RESP.
- ALU outputs hold their last values outside ISSUE.
- Opcodes are passed through unmodified. The ALU decodes 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL (low 32 bits), 110 SLT (unsigned).
- Reset values:
  - state IDLE, `rr_ptr` 0;
  - `rsp_valid` 0, `rsp_result` 0, `rsp_zero` 0, `rsp_err` 0;
  - `alu_src_a` 0, `alu_src_b` 0, `alu_control` 3'b000.
- Reset asserted mid-operation abandons the operation. No response is issued and the requester must re-request.
- Changes to `req_*` after the accept edge have no effect.

## Timing
- Accept edge at cycle N → ALU driven in cycle N+1 → `rsp_valid` high from cycle N+2.
- Minimum 3 cycles per operation. Throughput is one op per 3 cycles with `rsp_ready` held high.
- `rsp_*` are registered. `req_ready` is combinational from `req_valid` and `rr_ptr` only, never from `rsp_ready`.
- A requester holding `req_valid` high while another is served waits at most `NUM_REQ-1` grants.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
  - Opcodes 011 and 111 are accepted but not issued to the ALU.
  - ISSUE leaves the ALU outputs unchanged, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=1.
  - Timing is identical to a legal opcode.
- Not defined:
  - The `rsp_err` port is absent.
  - All opcodes are issued; the ALU returns 0 and zero=1 for 011/111.

## Structure
- Shared package `alu_pkg` holds:
  - ALU opcode localparams (`ALU_AND`…`ALU_SLT`);
  - FSM state enum/encoding;
  - the `DATA_W` default.
- One sub-module, `rr_grant`: parameterised round-robin priority picker (request vector + pointer → one-hot grant plus index). The FSM, operand registers and response registers live in the top.

## Test plan
- Single ADD: req 0, a=5, b=7, op=010 → `req_ready[0]` in the same cycle; `alu_control`=010 one cycle later; `rsp_valid[0]` two cycles after accept; result 12, zero 0.
- SUB zero: a=b=0x1234, op=100 → result 0, `rsp_zero`=1.
- Contention: both requesters valid from reset → grants 0,1,0,1 alternate; with requester 1 alone after a grant to 1, requester 1 is granted again.
- Backpressure: hold `rsp_ready` low 5 cycles → `rsp_valid` and result stable, `req_ready` all 0 throughout; one handshake then IDLE.
- Reset mid-ISSUE: assert `rst_n`=0 during ISSUE → all outputs reach reset values immediately, and no `rsp_valid` follows release.
- With `ALU_ARB_OPCHECK_EN`: op=111, a=3, b=4 → `rsp_err`=1, result 0; without the macro → result 0, zero 1.
